// File: rtl/matmul_ctrl_if.sv
// -----------------------------------------------------------------------------
// matmul_ctrl_if -- word-wide memory port of the matrix-multiply controller.
//
// Handshake: the master raises mem_req_o together with mem_we_o, mem_addr_o
// and (for writes) mem_wdata_o, and keeps all four unchanged until the slave
// answers with mem_gnt_i=1. The transfer completes in the grant cycle; for a
// read, mem_rdata_i is valid in that same cycle. A new request may follow
// immediately in the next cycle.
//
// Signals:
//   mem_req_o   master->slave  request
//   mem_we_o    master->slave  1=write, 0=read
//   mem_addr_o  master->slave  16-bit word address
//   mem_wdata_o master->slave  16-bit write data
//   mem_gnt_i   slave->master  grant, completes the current request
//   mem_rdata_i slave->master  16-bit read data, valid with the grant
// -----------------------------------------------------------------------------
interface matmul_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic [15:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rdata_i
  );
endinterface

// File: rtl/matmul_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_ctrl -- sequential C = A x B controller over a single memory port.
//
// For every output element C[i][j] it reads A[i][k] and B[k][j] for
// k = 0..N-1, accumulates the signed products, then writes the result.
// Matrices are row-major at word base addresses; all addressing wraps mod 2^16.
//
// Optional feature: define MATMUL_SAT_EN to saturate written results to the
// signed 16-bit range; otherwise results are truncated to acc[15:0].
//
// Ports:
//   pclk, preset_n      clock, synchronous active-low reset
//   matrix_*_addr_i     base word addresses of A, B, C (captured at start)
//   m_i, n_i, p_i       A is MxN, B is NxP, C is MxP (captured at start)
//   start_i             level start flag; a 0->1 edge in IDLE starts a run
//   end_o               one-cycle completion pulse
//   busy_o              high in every state except IDLE
//   state_o             current FSM state (debug visibility)
//   mem                 memory request port (matmul_ctrl_if.master)
// -----------------------------------------------------------------------------
module matmul_ctrl #(
  parameter int ACC_W = 32
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [15:0]          matrix_a_addr_i,
  input  logic [15:0]          matrix_b_addr_i,
  input  logic [15:0]          matrix_c_addr_i,
  input  logic [15:0]          m_i,
  input  logic [15:0]          n_i,
  input  logic [15:0]          p_i,
  input  logic                 start_i,
  output logic                 end_o,
  output logic                 busy_o,
  output logic [2:0]           state_o,
  matmul_ctrl_if.master        mem
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic               start_prev_q, start_prev_d;
  logic               armed_q, armed_d;
  logic [15:0]        m_q, m_d, n_q, n_d, p_q, p_d;
  logic [15:0]        b_base_q, b_base_d;
  logic [15:0]        a_row_q, a_row_d;    // A + i*N
  logic [15:0]        a_addr_q, a_addr_d;  // A + i*N + k
  logic [15:0]        b_col_q, b_col_d;    // B + j
  logic [15:0]        b_addr_q, b_addr_d;  // B + k*P + j
  logic [15:0]        c_addr_q, c_addr_d;  // C + i*P + j
  logic [15:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [15:0]        a_op_q, a_op_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic               start_edge;
  logic               zero_dim;
  logic               last_i, last_j, last_k;
  logic signed [31:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [15:0]        wr_data;

  // armed_q is cleared by reset and only set once start_i has been seen low,
  // so a start flag still held high across a reset cannot start a new run.
  assign start_edge = (state_q == S_IDLE) && start_i && !start_prev_q && armed_q;
  assign zero_dim   = (m_i == 16'd0) || (n_i == 16'd0) || (p_i == 16'd0);

  assign last_i = (i_q == m_q - 16'd1);
  assign last_j = (j_q == p_q - 16'd1);
  assign last_k = (k_q == n_q - 16'd1);

  assign prod     = 32'($signed(a_op_q)) * 32'($signed(mem.mem_rdata_i));
  assign prod_ext = ACC_W'(prod);

`ifdef MATMUL_SAT_EN
  logic sat_pos, sat_neg;
  // Bits above bit 15 must all equal the sign bit for the value to fit.
  assign sat_pos = !acc_q[ACC_W-1] && (|acc_q[ACC_W-2:15]);
  assign sat_neg =  acc_q[ACC_W-1] && !(&acc_q[ACC_W-2:15]);
  assign wr_data = sat_pos ? 16'h7FFF : (sat_neg ? 16'h8000 : acc_q[15:0]);
`else
  assign wr_data = acc_q[15:0];
`endif

  // State register and datapath registers
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      m_q          <= '0;
      n_q          <= '0;
      p_q          <= '0;
      b_base_q     <= '0;
      a_row_q      <= '0;
      a_addr_q     <= '0;
      b_col_q      <= '0;
      b_addr_q     <= '0;
      c_addr_q     <= '0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      a_op_q       <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      armed_q      <= armed_d;
      m_q          <= m_d;
      n_q          <= n_d;
      p_q          <= p_d;
      b_base_q     <= b_base_d;
      a_row_q      <= a_row_d;
      a_addr_q     <= a_addr_d;
      b_col_q      <= b_col_d;
      b_addr_q     <= b_addr_d;
      c_addr_q     <= c_addr_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      a_op_q       <= a_op_d;
      acc_q        <= acc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_edge) state_d = zero_dim ? S_DONE : S_RD_A;
      S_RD_A: if (mem.mem_gnt_i) state_d = S_RD_B;
      S_RD_B: if (mem.mem_gnt_i) state_d = last_k ? S_WR : S_RD_A;
      S_WR:   if (mem.mem_gnt_i) state_d = (last_i && last_j) ? S_DONE : S_RD_A;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counters and address pointers advance only on grants, so every
  // memory state holds its request unchanged while it waits.
  always_comb begin
    start_prev_d = start_i;
    armed_d      = armed_q | ~start_i;
    m_d          = m_q;
    n_d          = n_q;
    p_d          = p_q;
    b_base_d     = b_base_q;
    a_row_d      = a_row_q;
    a_addr_d     = a_addr_q;
    b_col_d      = b_col_q;
    b_addr_d     = b_addr_q;
    c_addr_d     = c_addr_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    a_op_d       = a_op_q;
    acc_d        = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          m_d      = m_i;
          n_d      = n_i;
          p_d      = p_i;
          b_base_d = matrix_b_addr_i;
          a_row_d  = matrix_a_addr_i;
          a_addr_d = matrix_a_addr_i;
          b_col_d  = matrix_b_addr_i;
          b_addr_d = matrix_b_addr_i;
          c_addr_d = matrix_c_addr_i;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
        end
      end
      S_RD_A: begin
        if (mem.mem_gnt_i) a_op_d = mem.mem_rdata_i;
      end
      S_RD_B: begin
        if (mem.mem_gnt_i) begin
          acc_d    = acc_q + prod_ext;
          k_d      = k_q + 16'd1;
          a_addr_d = a_addr_q + 16'd1;
          b_addr_d = b_addr_q + p_q;
        end
      end
      S_WR: begin
        if (mem.mem_gnt_i) begin
          acc_d    = '0;
          k_d      = '0;
          // C is walked linearly: the next element is always one word on.
          c_addr_d = c_addr_q + 16'd1;
          if (last_j) begin
            j_d      = '0;
            i_d      = i_q + 16'd1;
            a_row_d  = a_row_q + n_q;
            a_addr_d = a_row_q + n_q;
            b_col_d  = b_base_q;
            b_addr_d = b_base_q;
          end else begin
            j_d      = j_q + 16'd1;
            a_addr_d = a_row_q;
            b_col_d  = b_col_q + 16'd1;
            b_addr_d = b_col_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs, decoded from the current state only
  always_comb begin
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    case (state_q)
      S_RD_A: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = a_addr_q;
      end
      S_RD_B: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = b_addr_q;
      end
      S_WR: begin
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_addr_o  = c_addr_q;
        mem.mem_wdata_o = wr_data;
      end
      default: ;
    endcase
  end

  assign end_o   = (state_q == S_DONE);
  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_ctrl -- self-checking bench for matmul_ctrl.
// The expected read-address and write sequences are computed from plain
// matrix arithmetic over a bench-side memory array; a monitor compares every
// granted transfer, idle outputs, request stability and busy/end timing.
// -----------------------------------------------------------------------------
module tb_matmul_ctrl;
  localparam int ACC_W = 32;

  // ---------------- clock / reset ----------------
  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic [15:0] a_base = '0, b_base = '0, c_base = '0;
  logic [15:0] m_in = '0, n_in = '0, p_in = '0;
  logic        start_i = 1'b0;
  logic        end_o, busy_o;
  logic [2:0]  state_o;

  always #5 pclk = ~pclk;

  matmul_ctrl_if mif();

  matmul_ctrl #(.ACC_W(ACC_W)) dut (
    .pclk            (pclk),
    .preset_n        (preset_n),
    .matrix_a_addr_i (a_base),
    .matrix_b_addr_i (b_base),
    .matrix_c_addr_i (c_base),
    .m_i             (m_in),
    .n_i             (n_in),
    .p_i             (p_in),
    .start_i         (start_i),
    .end_o           (end_o),
    .busy_o          (busy_o),
    .state_o         (state_o),
    .mem             (mif)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] ram [0:65535];
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] wr_log[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit stall_en = 0;
  int stall_left = 0;
  int busy_cnt = 0, end_cnt = 0, stall_cnt = 0;
  bit prev_pend = 0, prev_end = 0;
  logic        prev_we;
  logic [15:0] prev_addr, prev_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] shape(input longint acc);
    logic [ACC_W-1:0] w;
    w = acc[ACC_W-1:0];
`ifdef MATMUL_SAT_EN
    begin
      longint v;
      v = longint'($signed(w));
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
    end
`endif
    return w[15:0];
  endfunction

  task automatic build_model(input logic [15:0] ab, bb, cb, input int m, n, p);
    exp_rd_q.delete();
    exp_wr_q.delete();
    if (m == 0 || n == 0 || p == 0) return;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < p; j++) begin
        longint acc;
        logic [15:0] ca;
        acc = 0;
        for (int k = 0; k < n; k++) begin
          logic [15:0] ra, rb;
          ra = 16'(int'(ab) + i * n + k);
          rb = 16'(int'(bb) + k * p + j);
          exp_rd_q.push_back(ra);
          exp_rd_q.push_back(rb);
          acc += longint'($signed(ram[ra])) * longint'($signed(ram[rb]));
        end
        ca = 16'(int'(cb) + i * p + j);
        exp_wr_q.push_back({ca, shape(acc)});
      end
    end
  endtask

  // ---------------- memory driver + compare process ----------------
  initial begin
    mif.mem_gnt_i   = 1'b0;
    mif.mem_rdata_i = '0;
    forever begin
      @(negedge pclk);
      if (mif.mem_req_o && stall_left == 0) begin
        mif.mem_gnt_i   = 1'b1;
        mif.mem_rdata_i = mif.mem_we_o ? 16'(  $urandom) : ram[mif.mem_addr_o];
      end else begin
        mif.mem_gnt_i   = 1'b0;
        mif.mem_rdata_i = 16'($urandom);
        if (mif.mem_req_o) stall_left--;
      end
      #1;
      if (!preset_n) begin
        prev_pend = 0;
        prev_end  = 0;
      end else begin
        if (!busy_o)
          check("idle_outputs", {end_o, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o}, '0);
        else
          busy_cnt++;
        if (end_o) begin
          end_cnt++;
          check("done_outputs", {mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o}, '0);
          check("end_width", prev_end, 0);
        end
        if (prev_pend)
          check("hold_stable", {mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o},
                {1'b1, prev_we, prev_addr, prev_wdata});
        if (mif.mem_req_o && mif.mem_gnt_i) begin
          stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
          if (!mif.mem_we_o) begin
            if (exp_rd_q.size() == 0) check("unexpected_read", mif.mem_addr_o, 16'hDEAD);
            else check("rd_addr", mif.mem_addr_o, exp_rd_q.pop_front());
          end else begin
            wr_log.push_back({mif.mem_addr_o, mif.mem_wdata_o});
            if (exp_wr_q.size() == 0) check("unexpected_write", {mif.mem_addr_o, mif.mem_wdata_o}, 32'hDEAD);
            else check("wr_addr_data", {mif.mem_addr_o, mif.mem_wdata_o}, exp_wr_q.pop_front());
          end
        end
        if (mif.mem_req_o && !mif.mem_gnt_i) stall_cnt++;
        prev_pend  = mif.mem_req_o && !mif.mem_gnt_i;
        prev_we    = mif.mem_we_o;
        prev_addr  = mif.mem_addr_o;
        prev_wdata = mif.mem_wdata_o;
        prev_end   = end_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_rand(input logic [15:0] base, input int cnt);
    for (int x = 0; x < cnt; x++) ram[16'(int'(base) + x)] = 16'($urandom);
  endtask

  task automatic run_op(input logic [15:0] ab, bb, cb, input int m, n, p,
                        input bit stall, output int end_cycle);
    bit done;
    int exp_busy;
    build_model(ab, bb, cb, m, n, p);
    wr_log.delete();
    done = 0;
    end_cycle = -1;
    @(negedge pclk);
    a_base = ab; b_base = bb; c_base = cb;
    m_in = 16'(m); n_in = 16'(n); p_in = 16'(p);
    stall_en = stall;
    stall_left = stall ? int'($urandom_range(0, 3)) : 0;
    busy_cnt = 0; end_cnt = 0; stall_cnt = 0;
    start_i = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge pclk);
      #2;
      if (c == 0) begin
        // captured values must not be disturbed by later input changes
        a_base = 16'($urandom); b_base = 16'($urandom); c_base = 16'($urandom);
        m_in = 16'($urandom_range(0, 5)); n_in = 16'($urandom_range(0, 5)); p_in = 16'($urandom_range(0, 5));
      end
      if (end_o) begin
        done = 1;
        end_cycle = c;
        break;
      end
    end
    if (!done) check("run_timeout", 0, 1);
    start_i = 1'b0;
    @(negedge pclk);
    #2;
    check("back_idle", busy_o, 0);
    exp_busy = (m == 0 || n == 0 || p == 0) ? 1 : m * p * (2 * n + 1) + 1;
    check("busy_cycles", busy_cnt, exp_busy + stall_cnt);
    check("end_pulses", end_cnt, 1);
    check("reads_left", exp_rd_q.size(), 0);
    check("writes_left", exp_wr_q.size(), 0);
  endtask

  task automatic load_2x2();
    ram[16'h0000] = 16'd1; ram[16'h0001] = 16'd2; ram[16'h0002] = 16'd3; ram[16'h0003] = 16'd4;
    ram[16'h0010] = 16'd5; ram[16'h0011] = 16'd6; ram[16'h0012] = 16'd7; ram[16'h0013] = 16'd8;
  endtask

  task automatic check_2x2_log(input string tag);
    logic [31:0] lit [4];
    lit[0] = {16'h0020, 16'd19}; lit[1] = {16'h0021, 16'd22};
    lit[2] = {16'h0022, 16'd43}; lit[3] = {16'h0023, 16'd50};
    check({tag, "_nwrites"}, wr_log.size(), 4);
    for (int x = 0; x < 4 && x < wr_log.size(); x++) check({tag, "_write"}, wr_log[x], lit[x]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ec;
    logic [15:0] ab, bb, cb;
    int m, n, p;

    repeat (3) @(negedge pclk);
    #2;
    check("reset_state", {busy_o, end_o, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o}, '0);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);

    // 2x2 worked example, grant always
    load_2x2();
    run_op(16'h0000, 16'h0010, 16'h0020, 2, 2, 2, 0, ec);
    check_2x2_log("mm2x2");
    check("mm2x2_busy_literal", busy_cnt, 21);

    // same with random grant stalls
    load_2x2();
    run_op(16'h0000, 16'h0010, 16'h0020, 2, 2, 2, 1, ec);
    check_2x2_log("mm2x2_stall");

    // zero dimensions
    run_op(16'h0000, 16'h0010, 16'h0020, 0, 2, 2, 0, ec);
    check("zero_m_end_latency", ec, 0);
    check("zero_m_no_writes", wr_log.size(), 0);
    run_op(16'h0000, 16'h0010, 16'h0020, 2, 0, 2, 0, ec);
    check("zero_n_end_latency", ec, 0);

    // 1x1x1 overflow of the 16-bit result
    ram[16'h0100] = 16'h7FFF;
    ram[16'h0200] = 16'h0002;
    run_op(16'h0100, 16'h0200, 16'h0300, 1, 1, 1, 0, ec);
`ifdef MATMUL_SAT_EN
    check("ovf_wdata", wr_log.size() > 0 ? wr_log[0] : 32'hX, {16'h0300, 16'h7FFF});
`else
    check("ovf_wdata", wr_log.size() > 0 ? wr_log[0] : 32'hX, {16'h0300, 16'hFFFE});
`endif

    // C address wrap
    load_rand(16'h0400, 1);
    load_rand(16'h0500, 2);
    run_op(16'h0400, 16'h0500, 16'hFFFF, 1, 1, 2, 0, ec);
    check("wrap_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("wrap_addr0", wr_log[0][31:16], 16'hFFFF);
      check("wrap_addr1", wr_log[1][31:16], 16'h0000);
    end

    // reset during RD_B with start held high
    load_2x2();
    build_model(16'h0000, 16'h0010, 16'h0020, 2, 2, 2);
    @(negedge pclk);
    a_base = 16'h0000; b_base = 16'h0010; c_base = 16'h0020;
    m_in = 16'd2; n_in = 16'd2; p_in = 16'd2;
    stall_en = 0; stall_left = 0; end_cnt = 0;
    start_i = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge pclk);
        #2;
        if (mif.mem_req_o && !mif.mem_we_o && mif.mem_addr_o == 16'h0010) begin
          seen = 1;
          break;
        end
      end
      if (!seen) check("rst_find_rd_b", 0, 1);
    end
    preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    #2;
    check("rst_outputs", {busy_o, end_o, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o}, '0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    busy_cnt = 0;
    preset_n = 1'b1;
    repeat (8) @(negedge pclk);
    #2;
    check("rst_no_retrigger", busy_cnt, 0);
    check("rst_no_end", end_cnt, 0);
    start_i = 1'b0;
    load_2x2();
    run_op(16'h0000, 16'h0010, 16'h0020, 2, 2, 2, 0, ec);
    check_2x2_log("after_rst");

    // randomized runs
    for (int t = 0; t < 8; t++) begin
      ab = 16'($urandom);
      bb = ab + 16'h0100;
      cb = 16'($urandom);
      m = int'($urandom_range(1, 3));
      n = int'($urandom_range(1, 3));
      p = int'($urandom_range(1, 3));
      load_rand(ab, m * n);
      load_rand(bb, n * p);
      run_op(ab, bb, cb, m, n, p, bit'($urandom_range(0, 1)), ec);
      check("rand_nwrites", wr_log.size(), m * p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 32, meaning accumulator width in bits (legal range 32..48).
REQ-002 SHALL have port pclk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port preset_n, input, 1, meaning the reset: synchronous, active-low.
REQ-004 SHALL have ports matrix_a_addr_i, matrix_b_addr_i and matrix_c_addr_i, input, 16 each, meaning the base word addresses of A, B and C.
REQ-005 SHALL have ports m_i, n_i and p_i, input, 16 each, meaning the dimensions: A is MxN, B is NxP, C is MxP.
REQ-006 SHALL have port start_i, input, 1, meaning the start flag, level-held by the register block.
REQ-007 SHALL have port end_o, output, 1, meaning the completion pulse to the register block.
REQ-008 SHALL have port busy_o, output, 1, meaning an operation is in progress.
REQ-009 SHALL have ports mem_req_o, output, 1, and mem_we_o, output, 1, meaning memory request and write enable.
REQ-010 SHALL have ports mem_addr_o, output, 16, and mem_wdata_o, output, 16, meaning memory word address and write data.
REQ-011 SHALL have ports mem_gnt_i, input, 1, and mem_rdata_i, input, 16, meaning grant and read data; read data is valid in the grant cycle.

Function
REQ-012 SHALL detect start as a rising edge of start_i (start_i=1 while the registered previous value=0) only in state IDLE; edges while busy SHALL be ignored.
REQ-013 SHALL, on start, capture all six address and dimension inputs into internal registers; later input changes SHALL NOT affect the running operation.
REQ-014 SHALL implement the states IDLE, RD_A, RD_B, WR and DONE.
REQ-015 SHALL transition IDLE -> DONE on start if any of M, N or P = 0; otherwise IDLE -> RD_A with i=j=k=0 and acc=0.
REQ-016 RD_A SHALL drive req=1, we=0 and addr=A+i*N+k; on grant it SHALL latch operand a and go to RD_B.
REQ-017 RD_B SHALL drive req=1, we=0 and addr=B+k*P+j; on grant it SHALL set acc += signed(a)*signed(mem_rdata_i) and k++. It SHALL go to WR if k was N-1, else to RD_A.
REQ-018 WR SHALL drive req=1, we=1, addr=C+i*P+j and wdata=the result per REQ-024.
REQ-019 WR, on grant, SHALL clear acc and k. It SHALL then go to DONE if i=M-1 and j=P-1; else, if j=P-1, it SHALL set j=0, i++ and go to RD_A; else it SHALL set j++ and go to RD_A.
REQ-020 Without a grant, each memory state SHALL hold its req, we, addr and wdata stable for any number of wait cycles.
REQ-021 DONE SHALL assert end_o for exactly one cycle and then return to IDLE.
REQ-022 SHALL compute addresses with incremental row and column pointers, not multipliers, and all address arithmetic SHALL wrap modulo 2^16.
REQ-023 SHALL compute products as signed 16x16 -> 32 and accumulate sign-extended into ACC_W bits, with wrap on overflow.
REQ-024 mem_wdata_o SHALL be acc[15:0] unless saturation is enabled per REQ-030.
REQ-025 busy_o SHALL equal (state != IDLE), including DONE.
REQ-026 With mem_gnt_i tied to 1, busy_o SHALL be high for exactly M*P*(2N+1)+1 cycles, or 1 cycle for a zero dimension.
REQ-027 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be 0 in IDLE and DONE.

Reset
REQ-028 SHALL, when preset_n=0 at a clock edge, set state=IDLE, clear all counters, acc, captured registers and the start-edge register, and drive all outputs to 0.
REQ-029 SHALL, on reset mid-operation, abandon the operation without asserting end_o; a start_i still high after reset SHALL NOT retrigger without a new 0->1 edge.

Configuration
REQ-030 With macro MATMUL_SAT_EN defined, wdata SHALL saturate acc to signed 16-bit (0x7FFF / 0x8000); without it, wdata SHALL be acc[15:0] (truncation).

Verification
REQ-031 SHALL cover: M=N=P=2, A=[1 2;3 4] at 0x0000, B=[5 6;7 8] at 0x0010, C at 0x0020, gnt=1 -> writes 19,22,43,50 to 0x0020..0x0023, busy 21 cycles, one end_o pulse.
REQ-032 SHALL cover: M=0, others 2 -> no mem_req_o, end_o pulse in the cycle after the start edge, busy 1 cycle.
REQ-033 SHALL cover: 1x1x1 with a=0x7FFF, b=0x0002 -> wdata 0x7FFF with MATMUL_SAT_EN, 0xFFFE without.
REQ-034 SHALL cover: REQ-031 with random 0-3 cycle grant stalls -> identical write sequence; addr, we and wdata stable while ungranted.
REQ-035 SHALL cover: C base 0xFFFF, M=1, N=1, P=2 -> writes to 0xFFFF then 0x0000.
REQ-036 SHALL cover: preset_n low during RD_B of a run with start_i held high -> IDLE and outputs 0, no end_o, no restart until start_i toggles 0->1.
